// File: rtl/timer_arbiter_if.sv
// Bundle between the timer_arbiter, its requesters and the shared timer.
// Latency: n/a (wires only).
// Backpressure: none; requesters hold req until granted or withdrawn.
//
// Signals:
//   req/cancel    per-requester request level and cancel
//   gnt           one-hot grant, held for the whole job
//   done/aborted  one-cycle one-hot completion/abort pulses
//   wdog_err      one-cycle pulse alongside aborted on a watchdog kill
//   busy/owner    job in progress and index of current/last owner
//   tmr_start/tmr_clr/tmr_pulse  timer START_TMR, CLR and PULSE
interface timer_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] cancel;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] aborted;
    logic             wdog_err;
    logic             busy;
    logic [IDX_W-1:0] owner;
    logic             tmr_start;
    logic             tmr_clr;
    logic             tmr_pulse;

    // requester/timer side
    modport master (
        output req, cancel, tmr_pulse,
        input  gnt, done, aborted, wdog_err, busy, owner, tmr_start, tmr_clr
    );

    // arbiter side
    modport slave (
        input  req, cancel, tmr_pulse,
        output gnt, done, aborted, wdog_err, busy, owner, tmr_start, tmr_clr
    );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one timer among N_REQ requesters, with cancel and watchdog abort.
// Latency: req -> gnt/tmr_start 1 cycle; tmr_pulse/cancel/watchdog -> done/aborted 1 cycle.
// Backpressure: req is a level held by the requester; one job at a time, others wait in req.
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset; abandons any job silently
//   bus  timer_arbiter_if.slave (req/cancel/tmr_pulse in, all other fields out, all registered)
module timer_arbiter #(
    parameter int          N_REQ    = 4,
    parameter int          IDX_W    = 2,
    parameter logic [20:0] WDOG_MAX = 21'h1F_FFFF
) (
    input  logic           clk,
    input  logic           rst,
    timer_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   owner_q, owner_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_nxt, rr_inc;
    logic [20:0]        wcnt, wcnt_nxt;

    logic [N_REQ-1:0]   gnt_q, gnt_nxt;
    logic [N_REQ-1:0]   done_q, done_nxt;
    logic [N_REQ-1:0]   aborted_q, aborted_nxt;
    logic               wdog_err_q, wdog_err_nxt;
    logic               busy_q, busy_nxt;
    logic               tmr_start_q, tmr_start_nxt;
    logic               tmr_clr_q, tmr_clr_nxt;

    logic [2*N_REQ-1:0] req_rot;
    logic [IDX_W:0]     sel_sum;
    logic [IDX_W:0]     inc_sum;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_vld;
    logic               cancel_own;
    logic               ev_done, ev_cancel, ev_wdog;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

    // State register; every output is a flop loaded from its *_nxt value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            owner_q     <= '0;
            rr_ptr      <= '0;
            wcnt        <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            aborted_q   <= '0;
            wdog_err_q  <= 1'b0;
            busy_q      <= 1'b0;
            tmr_start_q <= 1'b0;
            tmr_clr_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner_q     <= owner_nxt;
            rr_ptr      <= rr_nxt;
            wcnt        <= wcnt_nxt;
            gnt_q       <= gnt_nxt;
            done_q      <= done_nxt;
            aborted_q   <= aborted_nxt;
            wdog_err_q  <= wdog_err_nxt;
            busy_q      <= busy_nxt;
            tmr_start_q <= tmr_start_nxt;
            tmr_clr_q   <= tmr_clr_nxt;
        end
    end

    // Next-state logic: round-robin pick, job lifecycle, watchdog.
    always_comb begin
        // Rotate requests so bit 0 is the rr pointer position; scanning offsets
        // high-to-low leaves the lowest set offset (first from the pointer).
        req_rot = {bus.req, bus.req} >> rr_ptr;
        sel_vld = 1'b0;
        sel_sum = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                sel_vld = 1'b1;
                sel_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            end
        end
        sel_idx = (sel_sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sel_sum - (IDX_W+1)'(N_REQ))
                                                  : IDX_W'(sel_sum);

        inc_sum = {1'b0, owner_q} + 1'b1;
        rr_inc  = (inc_sum == (IDX_W+1)'(N_REQ)) ? '0 : IDX_W'(inc_sum);

        // gnt_q is one-hot on the owner, so masking picks out CANCEL[owner] only.
        cancel_own = |(bus.cancel & gnt_q);

        state_nxt = state;
        owner_nxt = owner_q;
        rr_nxt    = rr_ptr;
        wcnt_nxt  = wcnt;
        ev_done   = 1'b0;
        ev_cancel = 1'b0;
        ev_wdog   = 1'b0;

        case (state)
            S_IDLE: begin
                if (sel_vld) begin
                    state_nxt = S_START;
                    owner_nxt = sel_idx;
                end
            end
            S_START: begin
                state_nxt = S_WAIT;
                wcnt_nxt  = '0;
            end
            S_WAIT: begin
                // The first WAIT cycle sees count 0, so the kill is decided in the
                // WAIT cycle where the count equals WDOG_MAX.
                if (wcnt != '1) begin
                    wcnt_nxt = wcnt + 21'd1;
                end
                if (bus.tmr_pulse) begin
                    ev_done = 1'b1;
                end else if (cancel_own) begin
                    ev_cancel = 1'b1;
                end else if ((WDOG_MAX != 21'd0) && (wcnt == WDOG_MAX)) begin
                    ev_wdog = 1'b1;
                end
                if (ev_done || ev_cancel || ev_wdog) begin
                    state_nxt = S_IDLE;
                    rr_nxt    = rr_inc;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs.
    always_comb begin
        busy_nxt      = (state_nxt != S_IDLE);
        gnt_nxt       = busy_nxt ? onehot(owner_nxt) : '0;
        tmr_start_nxt = (state_nxt == S_START);
        done_nxt      = ev_done ? gnt_q : '0;
        aborted_nxt   = (ev_cancel || ev_wdog) ? gnt_q : '0;
        wdog_err_nxt  = ev_wdog;
        tmr_clr_nxt   = ev_cancel || ev_wdog;
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign bus.wdog_err  = wdog_err_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
    assign bus.tmr_start = tmr_start_q;
    assign bus.tmr_clr   = tmr_clr_q;
endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: table of jobs on a no-watchdog instance, plus
// hand-written watchdog, long-wait, reset and stray-pulse sequences.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_timer_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    timer_arbiter_if #(.N_REQ(N), .IDX_W(IW)) m_if ();
    timer_arbiter_if #(.N_REQ(N), .IDX_W(IW)) w_if ();

    timer_arbiter #(.N_REQ(N), .IDX_W(IW), .WDOG_MAX(21'd0)) u_main (
        .clk (clk),
        .rst (rst),
        .bus (m_if.slave)
    );

    timer_arbiter #(.N_REQ(N), .IDX_W(IW), .WDOG_MAX(21'd10)) u_wd (
        .clk (clk),
        .rst (rst),
        .bus (w_if.slave)
    );

    typedef struct {
        logic [N-1:0] req;
        int           owner;
        int           act;    // 0 pulse, 1 cancel owner, 2 pulse+cancel together
        int           delay;  // falling edges after the START cycle before acting
        logic [N-1:0] noise;  // non-owner cancel bits driven in the first WAIT cycle
    } vec_t;

    typedef struct packed {
        logic [N-1:0] done;
        logic [N-1:0] aborted;
        logic         wdog;
        logic         clr;
    } ev_t;

    ev_t  sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   jobs_started = 0;
    int   sb_pushes = 0;

    // written only by the monitor
    int   start_cnt = 0;
    int   multi_gnt = 0;
    int   ev_seen   = 0;
    int   overlap   = 0;

    always @(negedge clk) begin
        if (m_if.tmr_start === 1'b1) start_cnt++;
        if (((m_if.gnt & (m_if.gnt - 1'b1)) !== '0) && (^m_if.gnt !== 1'bx)) multi_gnt++;
        if ((m_if.done & m_if.aborted) !== '0 && (^m_if.done !== 1'bx)) multi_gnt++;
        if ((m_if.tmr_start === 1'b1 && m_if.tmr_clr === 1'b1) ||
            (w_if.tmr_start === 1'b1 && w_if.tmr_clr === 1'b1)) overlap++;
        if (|{m_if.done, m_if.aborted, m_if.wdog_err, m_if.tmr_clr} === 1'b1) ev_seen++;
    end

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v, input int row);
        ev_t e;
        ev_t got;
        m_if.req = v.req;
        @(negedge clk);
        jobs_started++;
        chk($sformatf("r%0d_gnt", row), 32'(m_if.gnt), 32'(oh(v.owner)));
        chk($sformatf("r%0d_owner", row), 32'(m_if.owner), 32'(v.owner));
        chk($sformatf("r%0d_start", row), 32'(m_if.tmr_start), 32'd1);
        for (int j = 1; j <= v.delay; j++) begin
            @(negedge clk);
            if (j == 1) begin
                chk($sformatf("r%0d_wait_start_low", row), 32'(m_if.tmr_start), 32'd0);
                chk($sformatf("r%0d_wait_busy", row), 32'(m_if.busy), 32'd1);
            end
            m_if.cancel = (j == 1 && j < v.delay) ? v.noise : '0;
        end
        m_if.cancel    = (v.act != 0) ? oh(v.owner) : '0;
        m_if.tmr_pulse = (v.act != 1);
        e.done    = (v.act != 1) ? oh(v.owner) : '0;
        e.aborted = (v.act == 1) ? oh(v.owner) : '0;
        e.wdog    = 1'b0;
        e.clr     = (v.act == 1);
        sb_q.push_back(e);
        sb_pushes++;
        @(negedge clk);
        m_if.cancel    = '0;
        m_if.tmr_pulse = 1'b0;
        e   = sb_q.pop_front();
        got = {m_if.done, m_if.aborted, m_if.wdog_err, m_if.tmr_clr};
        chk($sformatf("r%0d_event{done,abort,wdog,clr}", row), 32'(got), 32'(e));
        chk($sformatf("r%0d_gnt_drop", row), 32'(m_if.gnt), 32'd0);
        chk($sformatf("r%0d_busy_drop", row), 32'(m_if.busy), 32'd0);
    endtask

    vec_t vecs[14];
    vec_t fin;
    int   n;

    initial begin
        vecs[0]  = '{4'b1111, 0, 0, 1, 4'b0000};
        vecs[1]  = '{4'b1111, 1, 0, 2, 4'b0000};
        vecs[2]  = '{4'b1111, 2, 0, 3, 4'b0000};
        vecs[3]  = '{4'b1111, 3, 0, 4, 4'b0000};
        vecs[4]  = '{4'b1111, 0, 0, 1, 4'b0000};
        vecs[5]  = '{4'b1111, 1, 0, 2, 4'b0000};
        vecs[6]  = '{4'b1111, 2, 0, 3, 4'b0000};
        vecs[7]  = '{4'b1111, 3, 0, 4, 4'b0000};
        vecs[8]  = '{4'b0100, 2, 0, 4, 4'b0000};  // single request, pulse 4 after start
        vecs[9]  = '{4'b0010, 1, 1, 2, 4'b1000};  // cancel owner 1; cancel[3] ignored
        vecs[10] = '{4'b1010, 3, 2, 3, 4'b0000};  // pulse beats cancel
        vecs[11] = '{4'b1010, 1, 0, 2, 4'b0000};  // 3 just served -> 1 wins
        vecs[12] = '{4'b1001, 3, 0, 1, 4'b0000};
        vecs[13] = '{4'b1001, 0, 0, 1, 4'b0000};

        rst = 1'b1;
        m_if.req = '0; m_if.cancel = '0; m_if.tmr_pulse = 1'b0;
        w_if.req = '0; w_if.cancel = '0; w_if.tmr_pulse = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_main_outputs", 32'({m_if.gnt, m_if.done, m_if.aborted, m_if.wdog_err, m_if.busy,
                                        m_if.owner, m_if.tmr_start, m_if.tmr_clr}), 32'd0);
        chk("reset_wd_outputs", 32'({w_if.gnt, w_if.done, w_if.aborted, w_if.wdog_err, w_if.busy,
                                      w_if.owner, w_if.tmr_start, w_if.tmr_clr}), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_job(vecs[i], i);
            if (i == 7) chk("rr_start_count_8", 32'(start_cnt), 32'd8);
        end
        m_if.req = '0;

        // Watchdog at 10: first WAIT cycle has count 0, count 10 is seen 11 cycles
        // into WAIT, abort flags follow one cycle later (12 edges after START).
        w_if.req = 4'b0001;
        @(negedge clk);
        chk("wd_gnt", 32'(w_if.gnt), 32'b0001);
        w_if.req = '0;
        n = 0;
        while (n < 50 && w_if.aborted == '0) begin
            @(negedge clk);
            n++;
        end
        chk("wd_cycles_to_abort", 32'(n), 32'd12);
        chk("wd_aborted", 32'(w_if.aborted), 32'b0001);
        chk("wd_err", 32'(w_if.wdog_err), 32'd1);
        chk("wd_clr", 32'(w_if.tmr_clr), 32'd1);
        chk("wd_done", 32'(w_if.done), 32'd0);
        chk("wd_busy", 32'(w_if.busy), 32'd0);
        @(negedge clk);
        chk("wd_pulses_cleared", 32'({w_if.aborted, w_if.wdog_err, w_if.tmr_clr}), 32'd0);

        // No watchdog: WAIT persists; req changes after grant are ignored.
        m_if.req = 4'b0100;
        @(negedge clk);
        jobs_started++;
        chk("long_gnt", 32'(m_if.gnt), 32'b0100);
        m_if.req = 4'b0001;
        repeat (1000) @(negedge clk);
        chk("long_busy", 32'(m_if.busy), 32'd1);
        chk("long_gnt_held", 32'(m_if.gnt), 32'b0100);
        chk("long_owner", 32'(m_if.owner), 32'd2);

        // Reset mid-WAIT: silent abandon.
        m_if.req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_outputs", 32'({m_if.gnt, m_if.done, m_if.aborted, m_if.wdog_err, m_if.busy,
                                    m_if.owner, m_if.tmr_start, m_if.tmr_clr}), 32'd0);
        m_if.tmr_pulse = 1'b1;
        @(negedge clk);
        m_if.tmr_pulse = 1'b0;
        chk("stray_pulse_done", 32'(m_if.done), 32'd0);
        chk("stray_pulse_busy", 32'(m_if.busy), 32'd0);

        // rr pointer must be back at 0: all requesting -> requester 0.
        fin = '{4'b1111, 0, 0, 3, 4'b0000};
        run_job(fin, 99);
        m_if.req = '0;
        repeat (2) @(negedge clk);

        chk("start_count_total", 32'(start_cnt), 32'(jobs_started));
        chk("event_cycles", 32'(ev_seen), 32'(sb_pushes));
        chk("onehot_violations", 32'(multi_gnt), 32'd0);
        chk("clr_start_overlap", 32'(overlap), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
